bar_phase_decoder: RTL and testbench

BAR_PHASE_DECODER -- requirements
Module: bar_phase_decoder

---
 rtl/timing_pkg.sv | 21 ++
 rtl/bar_phase_decoder_if.sv | 31 +++
 rtl/halver_checker.sv | 32 +++
 rtl/bar_phase_decoder.sv | 142 ++++++++++++++
 tb/tb_bar_phase_decoder.sv | 194 +++++++++++++++++++
 5 files changed

// File: rtl/timing_pkg.sv
// Shared phase-state encodings and default timing constants for the bar phase decoder.
package timing_pkg;

    typedef enum logic [2:0] {
        PH_UNLOCKED = 3'd0,
        PH_IDLE     = 3'd1,
        PH_S1       = 3'd2,
        PH_YPLATE   = 3'd3,
        PH_AWAIT    = 3'd4,
        PH_ACTION   = 3'd5
    } phase_t;

    localparam int DEF_ACT_TIMEOUT = 8;
    localparam int DEF_STOP_GAP    = 4;
    localparam int DEF_CNT_W       = 16;

    function automatic logic halver_onehot(input logic hs, input logic ha);
        return hs ^ ha;
    endfunction

endpackage

// File: rtl/bar_phase_decoder_if.sv
// Beat/waveform inputs and decoded phase outputs of the bar phase decoder.
interface bar_phase_decoder_if #(
    parameter int CNT_W = 16
);
    logic             ready;
    logic             w_HS;
    logic             w_HA;
    logic             w_PP_WF;
    logic             w_ACTION_TRIGGER_AUTO;
    logic             w_ERR_CLR;
    logic             w_BAR_START;
    logic             w_S1_DEC;
    logic             w_ACTION_STROBE;
    logic             w_BAR_DONE;
    logic             w_STOPPED;
    logic             w_SEQ_ERR;
    logic [2:0]       b_PHASE;
    logic [CNT_W-1:0] b_BAR_CNT;

    modport master (
        output ready, w_HS, w_HA, w_PP_WF, w_ACTION_TRIGGER_AUTO, w_ERR_CLR,
        input  w_BAR_START, w_S1_DEC, w_ACTION_STROBE, w_BAR_DONE,
               w_STOPPED, w_SEQ_ERR, b_PHASE, b_BAR_CNT
    );

    modport slave (
        input  ready, w_HS, w_HA, w_PP_WF, w_ACTION_TRIGGER_AUTO, w_ERR_CLR,
        output w_BAR_START, w_S1_DEC, w_ACTION_STROBE, w_BAR_DONE,
               w_STOPPED, w_SEQ_ERR, b_PHASE, b_BAR_CNT
    );
endinterface

// File: rtl/halver_checker.sv
// Checks that locked halver beats are one-hot and alternate; err_stb flags a bad beat.
module halver_checker
    import timing_pkg::*;
(
    input  logic w_CLK,
    input  logic w_RST_N,
    input  logic ready,
    input  logic locked,
    input  logic w_HS,
    input  logic w_HA,
    output logic err_stb
);

    logic last_hs_reg;

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            last_hs_reg <= 1'b0;
        end else if (ready) begin
            if (!locked) begin
                if (w_HS && !w_HA) last_hs_reg <= 1'b1;
            end else if (halver_onehot(w_HS, w_HA)) begin
                last_hs_reg <= w_HS;
            end
        end
    end

    // A one-hot beat equal to the previous one is a repeat.
    assign err_stb = ready && locked &&
                     (!halver_onehot(w_HS, w_HA) || (w_HS == last_hs_reg));

endmodule

// File: rtl/bar_phase_decoder.sv
// Bar phase decoder FSM with timeout, stop detection and sticky sequence error.
// Optional completed-bar counter enabled by BAR_PHASE_BAR_COUNT_EN.
module bar_phase_decoder
    import timing_pkg::*;
#(
    parameter int ACT_TIMEOUT = DEF_ACT_TIMEOUT,
    parameter int STOP_GAP    = DEF_STOP_GAP,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic              w_CLK,
    input  logic              w_RST_N,
    bar_phase_decoder_if.slave bus
);

    localparam int TO_W  = $clog2(ACT_TIMEOUT + 1);
    localparam int GAP_W = $clog2(STOP_GAP + 1);

    phase_t             state_reg, state_next;
    logic [TO_W-1:0]    act_cnt_reg, act_cnt_next;
    logic [GAP_W-1:0]   gap_reg, gap_next;
    logic               fsm_err, halver_err;
    logic               bar_start_reg, bar_start_next;
    logic               s1_dec_reg, s1_dec_next;
    logic               strobe_reg, strobe_next;
    logic               done_reg, done_next;
    logic               stopped_reg, stopped_next;
    logic               err_reg, err_next;

    halver_checker u_halver (
        .w_CLK   (w_CLK),
        .w_RST_N (w_RST_N),
        .ready   (bus.ready),
        .locked  (state_reg != PH_UNLOCKED),
        .w_HS    (bus.w_HS),
        .w_HA    (bus.w_HA),
        .err_stb (halver_err)
    );

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) state_reg <= PH_UNLOCKED;
        else          state_reg <= state_next;
    end

    always_comb begin
        state_next   = state_reg;
        act_cnt_next = act_cnt_reg;
        fsm_err      = 1'b0;
        if (bus.ready) begin
            if (bus.w_ACTION_TRIGGER_AUTO && state_reg != PH_AWAIT) fsm_err = 1'b1;
            case (state_reg)
                PH_UNLOCKED: if (bus.w_HS && !bus.w_HA) state_next = PH_IDLE;
                PH_IDLE:     if (bus.w_PP_WF) state_next = PH_S1;
                PH_S1:       state_next = PH_YPLATE;
                PH_YPLATE:   if (bus.w_HA) state_next = PH_AWAIT;
                PH_AWAIT: begin
                    if (bus.w_ACTION_TRIGGER_AUTO) begin
                        state_next = PH_ACTION;
                    end else if (bus.w_PP_WF) begin
                        state_next = PH_S1;
                        fsm_err    = 1'b1;
                    end else if (act_cnt_reg == TO_W'(ACT_TIMEOUT - 1)) begin
                        state_next = PH_IDLE;
                        fsm_err    = 1'b1;
                    end else begin
                        act_cnt_next = act_cnt_reg + 1'b1;
                    end
                end
                PH_ACTION:   state_next = bus.w_PP_WF ? PH_S1 : PH_IDLE;
                default:     state_next = PH_UNLOCKED;
            endcase
            // Timeout counter is only meaningful while waiting for the trigger.
            if (state_reg != PH_AWAIT) act_cnt_next = '0;
        end
    end

    always_comb begin
        bar_start_next = (state_reg != PH_S1) && (state_next == PH_S1);
        s1_dec_next    = (state_next == PH_S1);
        strobe_next    = (state_reg == PH_AWAIT) && (state_next == PH_ACTION);
        done_next      = bus.ready && (state_reg == PH_ACTION);
        gap_next       = gap_reg;
        stopped_next   = stopped_reg;
        if (bus.ready) begin
            if (state_reg != PH_IDLE) begin
                gap_next = '0;
            end else if (bus.w_PP_WF) begin
                gap_next     = '0;
                stopped_next = 1'b0;
            end else begin
                if (gap_reg != GAP_W'(STOP_GAP)) gap_next = gap_reg + 1'b1;
                if (gap_reg >= GAP_W'(STOP_GAP - 1)) stopped_next = 1'b1;
            end
        end
        if (halver_err || fsm_err) err_next = 1'b1;
        else if (bus.w_ERR_CLR)    err_next = 1'b0;
        else                       err_next = err_reg;
    end

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N) begin
            act_cnt_reg   <= '0;
            gap_reg       <= '0;
            bar_start_reg <= 1'b0;
            s1_dec_reg    <= 1'b0;
            strobe_reg    <= 1'b0;
            done_reg      <= 1'b0;
            stopped_reg   <= 1'b1;
            err_reg       <= 1'b0;
        end else begin
            act_cnt_reg   <= act_cnt_next;
            gap_reg       <= gap_next;
            bar_start_reg <= bar_start_next;
            s1_dec_reg    <= s1_dec_next;
            strobe_reg    <= strobe_next;
            done_reg      <= done_next;
            stopped_reg   <= stopped_next;
            err_reg       <= err_next;
        end
    end

`ifdef BAR_PHASE_BAR_COUNT_EN
    logic [CNT_W-1:0] bar_cnt_reg;

    always_ff @(posedge w_CLK or negedge w_RST_N) begin
        if (!w_RST_N)                            bar_cnt_reg <= '0;
        else if (done_next && bar_cnt_reg != '1) bar_cnt_reg <= bar_cnt_reg + 1'b1;
    end

    assign bus.b_BAR_CNT = bar_cnt_reg;
`else
    assign bus.b_BAR_CNT = {CNT_W{1'b0}};
`endif

    assign bus.w_BAR_START     = bar_start_reg;
    assign bus.w_S1_DEC        = s1_dec_reg;
    assign bus.w_ACTION_STROBE = strobe_reg;
    assign bus.w_BAR_DONE      = done_reg;
    assign bus.w_STOPPED       = stopped_reg;
    assign bus.w_SEQ_ERR       = err_reg;
    assign bus.b_PHASE         = state_reg;

endmodule

// File: tb/tb_bar_phase_decoder.sv
// Directed bench for bar_phase_decoder: expected outputs queued per beat, checked one clock later.
module tb_bar_phase_decoder;
    import timing_pkg::*;

`ifdef BAR_PHASE_BAR_COUNT_EN
    localparam int TB_CNT_W = 4;
`else
    localparam int TB_CNT_W = 16;
`endif

    localparam logic [5:0] F_BS = 6'b100000;
    localparam logic [5:0] F_S1 = 6'b010000;
    localparam logic [5:0] F_AS = 6'b001000;
    localparam logic [5:0] F_BD = 6'b000100;
    localparam logic [5:0] F_ST = 6'b000010;
    localparam logic [5:0] F_ER = 6'b000001;

    typedef struct {
        logic [2:0]          ph;
        logic [5:0]          fl;
        logic [TB_CNT_W-1:0] cnt;
        string               tag;
    } exp_t;

    exp_t sb_q[$];
    logic w_CLK   = 1'b0;
    logic w_RST_N = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    logic hbit;
    logic [TB_CNT_W-1:0] exp_cnt;

    bar_phase_decoder_if #(.CNT_W(TB_CNT_W)) bus ();

    bar_phase_decoder #(.CNT_W(TB_CNT_W)) dut (
        .w_CLK   (w_CLK),
        .w_RST_N (w_RST_N),
        .bus     (bus)
    );

    always #5 w_CLK = ~w_CLK;

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] dut_flags();
        return {bus.w_BAR_START, bus.w_S1_DEC, bus.w_ACTION_STROBE,
                bus.w_BAR_DONE, bus.w_STOPPED, bus.w_SEQ_ERR};
    endfunction

    task automatic compare(input exp_t e);
        checks++;
        assert (bus.b_PHASE === e.ph) else begin
            errors++;
            $error("FAIL %s phase got %0d want %0d", e.tag, bus.b_PHASE, e.ph);
        end
        checks++;
        assert (dut_flags() === e.fl) else begin
            errors++;
            $error("FAIL %s flags{bs,s1,as,bd,st,er} got %b want %b", e.tag, dut_flags(), e.fl);
        end
        checks++;
        assert (bus.b_BAR_CNT === e.cnt) else begin
            errors++;
            $error("FAIL %s bar_cnt got %0d want %0d", e.tag, bus.b_BAR_CNT, e.cnt);
        end
        $display("step %-12s phase=%0d flags=%b cnt=%0d", e.tag, bus.b_PHASE, dut_flags(), bus.b_BAR_CNT);
    endtask

    task automatic raw(input string tag, input logic rdy, input logic hs, input logic ha,
                       input logic pp, input logic trig, input logic clr,
                       input logic [2:0] ph, input logic [5:0] fl);
        exp_t e;
        bus.ready                 = rdy;
        bus.w_HS                  = hs;
        bus.w_HA                  = ha;
        bus.w_PP_WF               = pp;
        bus.w_ACTION_TRIGGER_AUTO = trig;
        bus.w_ERR_CLR             = clr;
`ifdef BAR_PHASE_BAR_COUNT_EN
        if ((fl & F_BD) != 6'b0 && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
`endif
        e.ph = ph; e.fl = fl; e.cnt = exp_cnt; e.tag = tag;
        sb_q.push_back(e);
        @(posedge w_CLK);
        #1;
        e = sb_q.pop_front();
        compare(e);
    endtask

    task automatic beat(input string tag, input logic pp, input logic trig, input logic clr,
                        input logic [2:0] ph, input logic [5:0] fl);
        raw(tag, 1'b1, hbit, !hbit, pp, trig, clr, ph, fl);
        hbit = !hbit;
    endtask

    // From YPLATE: wait out an HS beat if one is due, then advance on HA.
    task automatic y2a(input string tag, input logic [5:0] fl);
        if (hbit) beat(tag, 1'b0, 1'b0, 1'b0, PH_YPLATE, fl);
        beat(tag, 1'b0, 1'b0, 1'b0, PH_AWAIT, fl);
    endtask

    task automatic check_reset(input string tag);
        exp_t e;
        e.ph = PH_UNLOCKED; e.fl = F_ST; e.cnt = '0; e.tag = tag;
        sb_q.push_back(e);
        e = sb_q.pop_front();
        compare(e);
    endtask

    initial begin
        bus.ready = 1'b0; bus.w_HS = 1'b0; bus.w_HA = 1'b0; bus.w_PP_WF = 1'b0;
        bus.w_ACTION_TRIGGER_AUTO = 1'b0; bus.w_ERR_CLR = 1'b0;
        hbit = 1'b1;
        exp_cnt = '0;
        #12;
        check_reset("reset");
        @(negedge w_CLK);
        w_RST_N = 1'b1;

        raw("unlk_00", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PH_UNLOCKED, F_ST);
        // First bar: lock, prepulse on beat 3, trigger later, completion.
        beat("lock",     1'b0, 1'b0, 1'b0, PH_IDLE,   F_ST);
        beat("idle",     1'b0, 1'b0, 1'b0, PH_IDLE,   F_ST);
        beat("pp",       1'b1, 1'b0, 1'b0, PH_S1,     F_BS | F_S1);
        beat("s1",       1'b0, 1'b0, 1'b0, PH_YPLATE, 6'b0);
        y2a("ypl", 6'b0);
        beat("await1",   1'b0, 1'b0, 1'b0, PH_AWAIT,  6'b0);
        beat("trig",     1'b0, 1'b1, 1'b0, PH_ACTION, F_AS);
        beat("done",     1'b0, 1'b0, 1'b0, PH_IDLE,   F_BD);

        // Illegal 11 beat, then clear; ready=0 hold; stop detection.
        raw("hh11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, PH_IDLE, F_ER);
        beat("errclr",   1'b0, 1'b0, 1'b1, PH_IDLE,   6'b0);
        raw("hold", 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, PH_IDLE, 6'b0);
        beat("gap3",     1'b0, 1'b0, 1'b0, PH_IDLE,   6'b0);
        beat("gap4",     1'b0, 1'b0, 1'b0, PH_IDLE,   F_ST);
        beat("restart",  1'b1, 1'b0, 1'b0, PH_S1,     F_BS | F_S1);

        // Repeated halver value, then timeout in AWAIT_ACTION.
        raw("repeat", 1'b1, !hbit, hbit, 1'b0, 1'b0, 1'b0, PH_YPLATE, F_ER);
        y2a("ypl2", F_ER);
        beat("clr2",     1'b0, 1'b0, 1'b1, PH_AWAIT,  6'b0);
        for (int i = 0; i < 6; i++) beat("wait", 1'b0, 1'b0, 1'b0, PH_AWAIT, 6'b0);
        raw("hold_aw", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, PH_AWAIT, 6'b0);
        beat("timeout",  1'b0, 1'b0, 1'b0, PH_IDLE,   F_ER);

        // Clear without ready; stray trigger; error beats clear in the same cycle.
        raw("clr_nordy", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, PH_IDLE, 6'b0);
        beat("trig_idle", 1'b0, 1'b1, 1'b0, PH_IDLE,  F_ER);
        beat("err_wins",  1'b0, 1'b1, 1'b1, PH_IDLE,  F_ER);
        beat("pp_clr",    1'b1, 1'b0, 1'b1, PH_S1,    F_BS | F_S1);
        beat("s1b",       1'b0, 1'b0, 1'b0, PH_YPLATE, 6'b0);
        y2a("ypl3", 6'b0);
        beat("pp_await",  1'b1, 1'b0, 1'b0, PH_S1,    F_BS | F_S1 | F_ER);
        beat("clr3",      1'b0, 1'b0, 1'b1, PH_YPLATE, 6'b0);
        y2a("ypl4", 6'b0);
        beat("trig_pp",   1'b1, 1'b1, 1'b0, PH_ACTION, F_AS);
        beat("pp_action", 1'b1, 1'b0, 1'b0, PH_S1,    F_BS | F_S1 | F_BD);

        // Back-to-back bars exercising the completed-bar count.
        for (int b = 0; b < 20; b++) begin
            beat("bar_s1",   1'b0, 1'b0, 1'b0, PH_YPLATE, 6'b0);
            y2a("bar_ypl", 6'b0);
            beat("bar_trig", 1'b0, 1'b1, 1'b0, PH_ACTION, F_AS);
            if (b < 19) beat("bar_next", 1'b1, 1'b0, 1'b0, PH_S1,   F_BS | F_S1 | F_BD);
            else        beat("bar_last", 1'b0, 1'b0, 1'b0, PH_IDLE, F_BD);
        end

        // Reset while waiting for the trigger discards the bar.
        beat("pp_r",  1'b1, 1'b0, 1'b0, PH_S1,     F_BS | F_S1);
        beat("s1_r",  1'b0, 1'b0, 1'b0, PH_YPLATE, 6'b0);
        y2a("ypl_r", 6'b0);
        #2;
        w_RST_N = 1'b0;
        #1;
        exp_cnt = '0;
        check_reset("rst_await");
        @(posedge w_CLK);
        #1;
        check_reset("rst_hold");
        @(negedge w_CLK);
        w_RST_N = 1'b1;
        hbit = 1'b1;
        beat("relock", 1'b0, 1'b0, 1'b0, PH_IDLE, F_ST);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
